// File: rtl/mul_seq24.sv
// mul_seq24: sequential shift-add multiplier, signed/unsigned operands, one product bit-step per clock
module mul_seq24 #(
  parameter int WIDTH = 24
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_signed,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          r_state;
  logic [PW-1:0]    r_mcand;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_product;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [PW-1:0]    w_sum;
  logic             w_accept;
  // Signed operands are reduced to magnitudes; -2^(W-1) maps onto itself, which is its correct unsigned magnitude.
  assign w_mag_a  = (i_signed & i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_mag_b  = (i_signed & i_b[WIDTH-1]) ? -i_b : i_b;
  assign w_sum    = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_accept = i_start & (r_state != RUN);
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_product = r_product;
  // Control and datapath: accept in IDLE/DONE, iterate LSB-first in RUN, publish the signed-corrected sum on the last step.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (w_accept) begin
      r_state  <= RUN;
      r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
      r_mplier <= w_mag_b;
      r_neg    <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
    end else if (r_state == RUN) begin
      r_acc    <= w_sum;
      r_mplier <= r_mplier >> 1;
      r_mcand  <= r_mcand << 1;
      r_cnt    <= r_cnt + CW'(1);
      if (r_cnt == CW'(WIDTH - 1)) begin
        r_state   <= DONE;
        r_busy    <= 1'b0;
        r_done    <= 1'b1;
        r_product <= r_neg ? -w_sum : w_sum;
      end
    end else begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mul_seq24.sv
// tb_mul_seq24: random and directed checks of mul_seq24 against a countdown/arithmetic reference model
module tb_mul_seq24;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic [23:0] a = '0;
  logic [23:0] b = '0;
  logic        busy;
  logic        done;
  logic [47:0] product;
  int n_checks = 0;
  int n_fail = 0;

  mul_seq24 dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_signed(sgn), .i_a(a), .i_b(b),
    .o_busy(busy), .o_done(done), .o_product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] ref_mul(input logic s, input logic [23:0] x, input logic [23:0] y);
    logic signed [47:0] sx, sy;
    logic [47:0] ux, uy;
    sx = {{24{x[23]}}, x};
    sy = {{24{y[23]}}, y};
    ux = {24'd0, x};
    uy = {24'd0, y};
    return s ? 48'(sx * sy) : 48'(ux * uy);
  endfunction

  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [47:0] m_prod = '0;
  logic [47:0] m_pend = '0;
  int          m_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_prod = '0;
      m_left = 0;
    end else if (!m_busy && start) begin
      m_busy = 1'b1;
      m_done = 1'b0;
      m_left = 24;
      m_pend = ref_mul(sgn, a, b);
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_prod = m_pend;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("busy", 48'(busy), 48'(m_busy));
    chk("done", 48'(done), 48'(m_done));
    chk("product", product, m_prod);
  end

  task automatic launch(input logic s, input logic [23:0] x, input logic [23:0] y);
    start = 1'b1;
    sgn = s;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic [47:0] exp);
    int n;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
    end
    chk({name, "_latency"}, 48'(n), 48'd24);
    chk(name, product, exp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("idle_product", product, 48'h0);
    chk("idle_busy", 48'(busy), 48'h0);
    launch(1'b0, 24'd3, 24'd5);
    chk("small_busy", 48'(busy), 48'h1);
    wait_done("small", 48'h00000000000F);
    @(negedge clk);
    chk("small_done_drop", 48'(done), 48'h0);
    launch(1'b0, 24'hFFFFFF, 24'hFFFFFF);
    wait_done("umax", 48'hFFFFFE000001);
    repeat (2) @(negedge clk);
    launch(1'b1, 24'hFFFFFF, 24'd1);
    wait_done("neg1", 48'hFFFFFFFFFFFF);
    repeat (2) @(negedge clk);
    launch(1'b1, 24'h800000, 24'h800000);
    wait_done("minmin", 48'h400000000000);
    repeat (2) @(negedge clk);
    launch(1'b1, 24'h800000, 24'h7FFFFF);
    wait_done("minmax", 48'hC00000800000);
    repeat (2) @(negedge clk);
    launch(1'b0, 24'd2, 24'd3);
    repeat (3) @(negedge clk);
    launch(1'b0, 24'd7, 24'd7);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("ignored_first", product, 48'd6);
    launch(1'b0, 24'd7, 24'd7);
    chk("b2b_busy", 48'(busy), 48'h1);
    wait_done("b2b", 48'd49);
    repeat (30) @(negedge clk);
    chk("b2b_product_held", product, 48'd49);
    launch(1'b0, 24'h000100, 24'h000100);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 48'(busy), 48'h0);
    chk("abort_product", product, 48'h0);
    chk("abort_done", 48'(done), 48'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    launch(1'b0, 24'h000100, 24'h000100);
    wait_done("after_abort", 48'h000000010000);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 7) == 0);
      sgn = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 5))
        0: a = 24'h800000;
        1: a = 24'hFFFFFF;
        2: a = 24'(($urandom_range(0, 15)));
        default: a = 24'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: b = 24'h800000;
        1: b = 24'h7FFFFF;
        2: b = 24'(($urandom_range(0, 15)));
        default: b = 24'($urandom);
      endcase
    end
    start = 1'b0;
    repeat (30) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
